// File: rtl/rsa_operand_fetch_if.sv
// Operand fetch bus: SRAM read port plus the word stream toward the RSA core.
interface rsa_operand_fetch_if;
  logic        sram_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [5:0]  out_idx;
  logic        out_last;

  modport master (
    output sram_en, sram_addr, out_valid, out_data, out_sel, out_idx, out_last,
    input  sram_data, out_ready
  );

  modport slave (
    input  sram_en, sram_addr, out_valid, out_data, out_sel, out_idx, out_last,
    output sram_data, out_ready
  );
endinterface

// File: rtl/rsa_operand_fetch.sv
// RSA operand fetch: streams message, key and modulus segments out of the
// input SRAM, one word per cycle when the consumer keeps up.
// Optional feature macro FETCH_CHECKSUM_EN: running XOR of delivered words.
module rsa_operand_fetch #(
  parameter int WORDS    = 64,
  parameter int BASE_MSG = 0,
  parameter int BASE_KEY = 64,
  parameter int BASE_N   = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  rsa_operand_fetch_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                checksum
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

  state_t     state_q, state_d;
  logic [1:0] iss_sel_q, iss_sel_d;     // segment of next word to issue
  logic [5:0] iss_idx_q, iss_idx_d;     // index of next word to issue
  logic       iss_all_q, iss_all_d;     // every word has been issued
  logic       ov_q, ov_d;
  logic [1:0] osel_q, osel_d;
  logic [5:0] oidx_q, oidx_d;
  logic       olast_q, olast_d;

  logic       hs;
  logic       issue;
  logic [7:0] base;

  // Issue only when the output slot is free or draining this cycle, so the
  // SRAM data register is never overwritten under a stalled word.
  always_comb begin
    hs    = ov_q & bus.out_ready;
    issue = (state_q == RUN) & ~abort & ~iss_all_q & (~ov_q | bus.out_ready);
    case (iss_sel_q)
      2'd0:    base = 8'(BASE_MSG);
      2'd1:    base = 8'(BASE_KEY);
      default: base = 8'(BASE_N);
    endcase
  end

  // Next-state, issue counters and output tag registers.
  always_comb begin
    state_d   = state_q;
    iss_sel_d = iss_sel_q;
    iss_idx_d = iss_idx_q;
    iss_all_d = iss_all_q;
    ov_d      = ov_q;
    osel_d    = osel_q;
    oidx_d    = oidx_q;
    olast_d   = olast_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          iss_sel_d = 2'd0;
          iss_idx_d = 6'd0;
          iss_all_d = 1'b0;
          ov_d      = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          ov_d      = 1'b0;
          iss_sel_d = 2'd0;
          iss_idx_d = 6'd0;
          iss_all_d = 1'b0;
        end else begin
          if (issue) begin
            ov_d    = 1'b1;
            osel_d  = iss_sel_q;
            oidx_d  = iss_idx_q;
            olast_d = (iss_sel_q == 2'd2) && (iss_idx_q == LAST_IDX);
            if (iss_idx_q == LAST_IDX) begin
              iss_idx_d = 6'd0;
              if (iss_sel_q == 2'd2) iss_all_d = 1'b1;
              else                   iss_sel_d = iss_sel_q + 2'd1;
            end else begin
              iss_idx_d = iss_idx_q + 6'd1;
            end
          end else if (hs) begin
            ov_d = 1'b0;
          end
          // The last word is issued before its handshake, so no issue can
          // collide with the final handshake.
          if (hs && olast_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iss_sel_q <= 2'd0;
      iss_idx_q <= 6'd0;
      iss_all_q <= 1'b0;
      ov_q      <= 1'b0;
      osel_q    <= 2'd0;
      oidx_q    <= 6'd0;
      olast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_sel_q <= iss_sel_d;
      iss_idx_q <= iss_idx_d;
      iss_all_q <= iss_all_d;
      ov_q      <= ov_d;
      osel_q    <= osel_d;
      oidx_q    <= oidx_d;
      olast_q   <= olast_d;
    end
  end

  assign bus.sram_en   = issue;
  assign bus.sram_addr = issue ? base + {2'b00, iss_idx_q} : 8'd0;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = bus.sram_data;
  assign bus.out_sel   = osel_q;
  assign bus.out_idx   = oidx_q;
  assign bus.out_last  = olast_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);

`ifdef FETCH_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // Cleared on an accepted start, folds in every delivered word.
  always_comb begin
    cks_d = cks_q;
    if (state_q == IDLE && start && !abort)   cks_d = 32'd0;
    else if (state_q == RUN && !abort && hs)  cks_d = cks_q ^ bus.sram_data;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cks_q <= 32'd0;
    else        cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: doc/rsa_operand_fetch.md
RSA_OPERAND_FETCH -- requirements
Module: rsa_operand_fetch

Interface
REQ-001 SHALL have parameter WORDS, default 64, words per operand segment.
REQ-002 SHALL have parameter BASE_MSG, default 0, message segment base address.
REQ-003 SHALL have parameter BASE_KEY, default 64, exponent (D/E key) segment base address.
REQ-004 SHALL have parameter BASE_N, default 128, modulus segment base address.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to fetch all three operands.
REQ-008 SHALL have port abort  input  1  synchronous cancel of an in-progress fetch.
REQ-009 SHALL have port sram_en  output  1  read enable to the input SRAM.
REQ-010 SHALL have port sram_addr  output  8  read address to the input SRAM.
REQ-011 SHALL have port sram_data  input  32  SRAM read data, valid the cycle after an enabled address, held while sram_en=0.
REQ-012 SHALL have port out_valid  output  1  out_data/out_sel/out_idx/out_last valid.
REQ-013 SHALL have port out_ready  input  1  downstream RSA core accepts the word.
REQ-014 SHALL have port out_data  output  32  operand word (combinational from sram_data).
REQ-015 SHALL have port out_sel  output  2  segment: 0 message, 1 key, 2 modulus.
REQ-016 SHALL have port out_idx  output  6  word index within segment, 0..WORDS-1.
REQ-017 SHALL have port out_last  output  1  high with the final word of the modulus segment.
REQ-018 SHALL have port busy  output  1  high in RUN.
REQ-019 SHALL have port done  output  1  one-cycle pulse after final handshake.
REQ-020 SHALL have port checksum  output  32  XOR of all delivered words (see Configuration).

Function
REQ-021 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on final handshake, DONE->IDLE unconditionally next cycle.
REQ-022 SHALL ignore start while in RUN or DONE.
REQ-023 SHALL fetch in order message idx 0..WORDS-1, key 0..WORDS-1, modulus 0..WORDS-1 (3*WORDS words); sram_addr = segment base + idx, 8-bit wrap.
REQ-024 SHALL assert sram_en in RUN only when words remain unissued and (out_valid=0 or out_ready=1).
REQ-025 SHALL set out_valid the cycle after each issue; clear it on handshake (out_valid&out_ready) when no new issue occurs that cycle.
REQ-026 SHALL hold out_data, out_sel, out_idx, out_last stable while out_valid=1 and out_ready=0, relying on sram_en=0 holding SRAM data.
REQ-027 SHALL sustain one word per cycle with out_ready held high; first out_valid 2 cycles after start (1 cycle to RUN, 1 SRAM latency).
REQ-028 SHALL assert done for exactly one cycle in DONE; busy low in DONE.
REQ-029 SHALL, on abort in RUN, return to IDLE next cycle, clear out_valid, deassert sram_en, not pulse done; abort has priority over a simultaneous final handshake.
REQ-030 SHALL ignore abort outside RUN; start asserted with abort in IDLE is ignored.

Reset
REQ-031 SHALL on rst_n=0 immediately force IDLE, sram_en=0, sram_addr=0, out_valid=0, out_sel=0, out_idx=0, out_last=0, busy=0, done=0, checksum=0, counters=0.
REQ-032 SHALL discard any partial fetch on reset mid-operation; the next start restarts from message idx 0.

Configuration
REQ-033 SHALL, with FETCH_CHECKSUM_EN defined, clear checksum on accepted start and XOR in out_data on each handshake, holding the value after done until the next start.
REQ-034 SHALL, without FETCH_CHECKSUM_EN, tie checksum to 0 and instantiate no checksum register.

Verification
REQ-035 SHALL cover: start, out_ready=1 always -> 192 words, addresses 0..191 contiguous, out_last only on sel=2 idx=63, done pulse exactly 1 cycle after it.
REQ-036 SHALL cover: out_ready toggled 1/0 each cycle -> no word lost or duplicated, data stable during stalls, 192 handshakes total.
REQ-037 SHALL cover: abort at word 100 -> out_valid=0 next cycle, no done; new start -> first word sel=0 idx=0 addr 0.
REQ-038 SHALL cover: rst_n low for 1 cycle at word 70 (sel=1 idx=6) -> all outputs at reset values asynchronously, state IDLE.
REQ-039 SHALL cover: start pulsed again at word 50 -> ignored, sequence unaffected.
REQ-040 SHALL cover: FETCH_CHECKSUM_EN defined, SRAM words i = i+1 -> checksum equals XOR of 1..192 = 0x000000C0 after done; undefined -> checksum 0.
